// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM request queue: request record, width defaults,
// and the issue sequencer state encoding.
package sdram_pkg;

    localparam int ADDR_W_DEF = 26;
    localparam int DATA_W_DEF = 16;

    // One queued request: {chip, bank[1:0], row[12:0], col[9:0]} address.
    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock in-order FIFO. Caller guarantees no push when full and no pop
// when empty; full/empty are derived from the registered count.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage carries no reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at DEPTH (power of two); push+pop keeps count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/sdram_req_queue.sv
// Request buffer and issue sequencer in front of the SDRAM controller.
// One request outstanding at a time keeps reads coherent with earlier writes.
module sdram_req_queue
    import sdram_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_val,
    output logic              busy,
    output logic              stray_rdata
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMO_W = $clog2(RD_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

    state_t            state, state_n;
    mem_req_t          push_req, head_req;
    logic              fifo_full, fifo_empty, push, pop;
    logic [CNT_W-1:0]  fifo_count;
    logic [TMO_W-1:0]  tmo_cnt, tmo_n;
    logic              mem_read_n, mem_write_n, rsp_valid_n, rsp_err_n, stray_n;
    logic              rd_taken;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n, rsp_data_n;

    assign push_req  = '{we: req_we, addr: req_addr, wdata: req_wdata};
    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(mem_req_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (push_req),
        .pop     (pop),
        .dout    (head_req),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_n;
    end

    // Next state, pop, and next values for the registered controller/response outputs.
    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        mem_read_n  = mem_read;
        mem_write_n = mem_write;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        tmo_n       = tmo_cnt;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_data_n  = rsp_data;
        rd_taken    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    mem_addr_n  = head_req.addr;
                    mem_wdata_n = head_req.wdata;
                    mem_write_n = head_req.we;
                    mem_read_n  = !head_req.we;
                    state_n     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_done) begin
                    mem_read_n  = 1'b0;
                    mem_write_n = 1'b0;
                    tmo_n       = '0;
                    if (mem_write) begin
                        state_n = ST_IDLE;
                    end else if (mem_rdata_val) begin
                        // Data arriving on the done edge counts as the read response.
                        rd_taken    = 1'b1;
                        rsp_valid_n = 1'b1;
                        rsp_data_n  = mem_rdata;
                        state_n     = ST_IDLE;
                    end else begin
                        state_n = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (mem_rdata_val) begin
                    rd_taken    = 1'b1;
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = mem_rdata;
                    state_n     = ST_IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    rsp_data_n  = '0;
                    state_n     = ST_IDLE;
                end else begin
                    tmo_n = tmo_cnt + TMO_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
        stray_n = stray_rdata || (mem_rdata_val && !rd_taken);
    end

    // Registered controller strobes, response pulse, timeout count and sticky stray flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            tmo_cnt     <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_data    <= '0;
            stray_rdata <= 1'b0;
        end else begin
            mem_read    <= mem_read_n;
            mem_write   <= mem_write_n;
            mem_addr    <= mem_addr_n;
            mem_wdata   <= mem_wdata_n;
            tmo_cnt     <= tmo_n;
            rsp_valid   <= rsp_valid_n;
            rsp_err     <= rsp_err_n;
            rsp_data    <= rsp_data_n;
            stray_rdata <= stray_n;
        end
    end

endmodule

// File: tb/tb_sdram_req_queue.sv
// Bench for sdram_req_queue: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sdram_req_queue;

    localparam int DEPTH      = 8;
    localparam int ADDR_W     = 26;
    localparam int DATA_W     = 16;
    localparam int RD_TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_rdata_val = 1'b0;
    logic              busy, stray_rdata;

    sdram_req_queue #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_rdata_val(mem_rdata_val),
        .busy(busy), .stray_rdata(stray_rdata)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- controller responder ----------------
    int   done_dly = 1;     // strobe cycle index at which mem_done is given
    int   rd_dly   = 1;     // cycles after the done cycle for read data; -1 = never
    logic hold_done = 1'b0;
    logic stray_pulse = 1'b0;
    logic [DATA_W-1:0] rd_word = '0;
    int   age = 0;
    int   rd_pend = -1;

    initial forever begin
        @(negedge clk);
        mem_done      = 1'b0;
        mem_rdata_val = 1'b0;
        mem_rdata     = '0;
        if (!reset_n) begin
            age = 0;
            rd_pend = -1;
        end else begin
            if (mem_read || mem_write) begin
                if (!hold_done && age >= done_dly) begin
                    mem_done = 1'b1;
                    if (mem_read && rd_dly >= 0) rd_pend = rd_dly;
                end
                age++;
            end else begin
                age = 0;
            end
            if (rd_pend == 0) begin
                mem_rdata_val = 1'b1;
                mem_rdata     = rd_word;
                rd_pend       = -1;
            end else if (rd_pend > 0) begin
                rd_pend--;
            end
            if (stray_pulse) begin
                mem_rdata_val = 1'b1;
                stray_pulse   = 1'b0;
            end
        end
    end

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    req_t q[$];
    req_t cur;
    bit   have_cur = 0;
    bit   waiting  = 0;     // read command issued, data pending
    int   deadline = 0;     // edge at which a pending read gives up
    int   cyc = 0;
    bit   e_rsp_v = 0, e_rsp_e = 0, e_stray = 0;
    logic [DATA_W-1:0] e_rsp_d = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            have_cur = 0; waiting = 0;
            e_rsp_v = 0; e_rsp_e = 0; e_stray = 0;
        end else begin
            int  pre;
            bit  taken;
            pre = q.size();
            taken = 0;
            e_rsp_v = 0; e_rsp_e = 0;
            if (!have_cur) begin
                if (pre > 0) begin
                    cur = q.pop_front();
                    have_cur = 1;
                    waiting = 0;
                end
            end else if (!waiting) begin
                if (mem_done) begin
                    if (cur.we) have_cur = 0;
                    else if (mem_rdata_val) begin
                        taken = 1; e_rsp_v = 1; e_rsp_d = mem_rdata; have_cur = 0;
                    end else begin
                        waiting = 1;
                        deadline = cyc + RD_TIMEOUT;
                    end
                end
            end else begin
                if (mem_rdata_val) begin
                    taken = 1; e_rsp_v = 1; e_rsp_d = mem_rdata; have_cur = 0;
                end else if (cyc == deadline) begin
                    e_rsp_v = 1; e_rsp_e = 1; e_rsp_d = '0; have_cur = 0;
                end
            end
            if (mem_rdata_val && !taken) e_stray = 1;
            if (req_valid && pre < DEPTH)
                q.push_back('{we: req_we, addr: req_addr, wdata: req_wdata});
            cyc++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        bit e_rd, e_wr;
        e_rd = have_cur && !waiting && !cur.we;
        e_wr = have_cur && !waiting && cur.we;
        chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
        chk("busy", 32'(busy), 32'(have_cur || q.size() > 0));
        chk("mem_read", 32'(mem_read), 32'(e_rd));
        chk("mem_write", 32'(mem_write), 32'(e_wr));
        chk("strobe_excl", 32'(mem_read && mem_write), 32'(0));
        if (e_rd || e_wr) begin
            chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_v));
        if (e_rsp_v) begin
            chk("rsp_err", 32'(rsp_err), 32'(e_rsp_e));
            chk("rsp_data", 32'(rsp_data), 32'(e_rsp_d));
        end
        chk("stray_rdata", 32'(stray_rdata), 32'(e_stray));
    end

    // Response log for the directed checks.
    int rsp_cnt = 0;
    logic [DATA_W-1:0] last_d = '0;
    logic last_e = 1'b0;
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            rsp_cnt++;
            last_d = rsp_data;
            last_e = rsp_err;
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic send(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit ok;
        ok = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        for (int t = 0; t < 300 && !ok; t++) begin
            ok = req_ready;
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (!ok) chk("send_accept", 32'(ok), 32'(1));
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 400 && busy; t++) @(negedge clk);
        chk("drain", 32'(busy), 32'(0));
        @(negedge clk);
    endtask

    initial begin
        int c0, h, g, t;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_strobes", 32'({mem_read, mem_write}), 32'(0));
        chk("rst_rsp", 32'({rsp_valid, rsp_err}), 32'(0));
        chk("rst_stray", 32'(stray_rdata), 32'(0));

        // Write then read the same address.
        done_dly = 3; rd_dly = 2; rd_word = 16'hBEEF;
        c0 = rsp_cnt;
        send(1'b1, 26'h0001234, 16'hBEEF);
        send(1'b0, 26'h0001234, 16'h0000);
        wait_idle();
        chk("wr_rd_count", 32'(rsp_cnt - c0), 32'(1));
        chk("wr_rd_data", 32'(last_d), 32'h0000BEEF);
        chk("wr_rd_err", 32'(last_e), 32'(0));

        // Fill: 1 in flight + DEPTH queued, the next one stalls.
        done_dly = 1; rd_dly = 1; rd_word = 16'h0F0F; hold_done = 1'b1;
        for (int i = 0; i < 9; i++)
            send((i % 3) != 2, 26'h100 + 26'(i), 16'h1000 + 16'(i));
        chk("fill_ready_low", 32'(req_ready), 32'(0));
        req_valid = 1'b1; req_we = 1'b1; req_addr = 26'h1FF; req_wdata = 16'h1AAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fill_stalled", 32'(req_ready), 32'(0));
        end
        @(posedge clk); #1 hold_done = 1'b0;
        @(negedge clk); chk("fill_done_cyc", 32'(req_ready), 32'(0));
        @(negedge clk); chk("fill_pop_cyc", 32'(req_ready), 32'(0));
        @(negedge clk); chk("fill_ready_rise", 32'(req_ready), 32'(1));
        @(negedge clk); req_valid = 1'b0;
        wait_idle();

        // Read timeout, then the queued write issues.
        done_dly = 1; rd_dly = -1;
        send(1'b0, 26'h2ABCDEF, 16'h0000);
        send(1'b1, 26'h0000555, 16'h5A5A);
        for (t = 0; t < 20 && !mem_read; t++) @(negedge clk);
        for (t = 0; t < 20 && mem_read; t++) @(negedge clk);
        for (t = 0; t < 200 && !rsp_valid; t++) @(negedge clk);
        chk("tmo_latency", 32'(t), 32'(RD_TIMEOUT));
        chk("tmo_err", 32'(rsp_err), 32'(1));
        chk("tmo_data", 32'(rsp_data), 32'(0));
        for (t = 0; t < 20 && !mem_write; t++) @(negedge clk);
        chk("tmo_next_addr", 32'(mem_addr), 32'h0000555);
        wait_idle();

        // Stray read data while idle.
        c0 = rsp_cnt;
        @(posedge clk); #1 stray_pulse = 1'b1;
        repeat (3) @(negedge clk);
        chk("stray_set", 32'(stray_rdata), 32'(1));
        chk("stray_no_rsp", 32'(rsp_cnt - c0), 32'(0));
        repeat (5) @(negedge clk);
        chk("stray_sticky", 32'(stray_rdata), 32'(1));

        // Done in the first strobe cycle: 1-cycle strobe, 1 idle cycle between.
        done_dly = 0; rd_dly = -1;
        send(1'b1, 26'h0000010, 16'h0001);
        send(1'b1, 26'h0000020, 16'h0002);
        h = 0; g = 0;
        while (mem_write && h < 10) begin h++; @(negedge clk); end
        while (!mem_write && g < 10) begin g++; @(negedge clk); end
        chk("same_cyc_high", 32'(h), 32'(1));
        chk("same_cyc_gap", 32'(g), 32'(1));
        chk("same_cyc_addr2", 32'(mem_addr), 32'h0000020);
        wait_idle();
        rd_dly = 0; rd_word = 16'h1357;
        send(1'b0, 26'h0000030, 16'h0000);
        wait_idle();
        chk("same_cyc_rdata", 32'(last_d), 32'h00001357);
        chk("same_cyc_rerr", 32'(last_e), 32'(0));

        // Reset during a read with three requests queued.
        done_dly = 1; rd_dly = 1; hold_done = 1'b1;
        send(1'b0, 26'h0000333, 16'h0000);
        send(1'b0, 26'h0000334, 16'h0000);
        send(1'b1, 26'h0000335, 16'h0335);
        send(1'b1, 26'h0000336, 16'h0336);
        chk("rst_mid_read_on", 32'(mem_read), 32'(1));
        c0 = rsp_cnt;
        @(posedge clk); #2 reset_n = 1'b0;
        #1 chk("rst_mid_read_drop", 32'(mem_read), 32'(0));
        @(negedge clk); hold_done = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2 reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_mid_ready", 32'(req_ready), 32'(1));
        chk("rst_mid_busy", 32'(busy), 32'(0));
        chk("rst_mid_no_rsp", 32'(rsp_cnt - c0), 32'(0));
        chk("rst_mid_stray", 32'(stray_rdata), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
